// File: rtl/n_sort_if.sv
// Stream bundle for n_sort: element load side, sorted output side and status.
interface n_sort_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             last_in;
  logic             descend_in;
  logic             ready_out;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             last_out;
  logic             ready_in;
  logic             busy_out;

  modport slave (
    input  data_in, valid_in, last_in, descend_in, ready_in,
    output ready_out, data_out, valid_out, last_out, busy_out
  );

  modport master (
    output data_in, valid_in, last_in, descend_in, ready_in,
    input  ready_out, data_out, valid_out, last_out, busy_out
  );
endinterface

// File: rtl/n_sort.sv
// Sequential odd-even transposition sorter: load up to DEPTH words, run DEPTH
// passes, then stream the frame out in ascending or descending order.
module n_sort #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic   clk_in,
  input  logic   rst_in,
  n_sort_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

  state_e           r_state, w_state_d;
  logic [CW-1:0]    r_count, w_count_d;
  logic [CW-1:0]    r_rd_idx, w_rd_idx_d;
  logic [PW-1:0]    r_pass, w_pass_d;
  logic             r_desc, w_desc_d;
  logic [WIDTH-1:0] r_slot [DEPTH];
  logic [WIDTH-1:0] w_slot_d [DEPTH];

  logic             w_ready, w_valid, w_last_rd, w_accept, w_xfer;
  logic [WIDTH-1:0] w_rd_data;

  // Outputs are decoded from registered state only.
  assign w_ready   = (r_state == StLoad);
  assign w_valid   = (r_state == StDrain);
  assign w_last_rd = (r_rd_idx == r_count - CW'(1));
  assign w_accept  = w_ready & bus.valid_in;
  assign w_xfer    = w_valid & bus.ready_in;

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (CW'(i) == r_rd_idx) w_rd_data = r_slot[i];
    end
  end

  assign bus.ready_out = w_ready;
  assign bus.valid_out = w_valid;
  assign bus.last_out  = w_valid & w_last_rd;
  assign bus.data_out  = w_valid ? w_rd_data : '0;
  assign bus.busy_out  = ~w_ready;

  always_comb begin
    w_state_d  = r_state;
    w_count_d  = r_count;
    w_rd_idx_d = r_rd_idx;
    w_pass_d   = r_pass;
    w_desc_d   = r_desc;
    w_slot_d   = r_slot;
    case (r_state)
      StLoad: begin
        if (w_accept) begin
          for (int i = 0; i < int'(DEPTH); i++) begin
            if (CW'(i) == r_count) w_slot_d[i] = bus.data_in;
          end
          if (r_count == '0) w_desc_d = bus.descend_in;
          w_count_d = r_count + CW'(1);
          if (bus.last_in || (w_count_d == CW'(DEPTH))) begin
            w_state_d = StSort;
            w_pass_d  = '0;
          end
        end
      end
      StSort: begin
        // Pairs of one pass are disjoint, so all swaps read the current slots.
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          if ((i[0] == r_pass[0]) && (CW'(i + 1) < r_count)) begin
            if (r_desc ? (r_slot[i] < r_slot[i+1]) : (r_slot[i] > r_slot[i+1])) begin
              w_slot_d[i]   = r_slot[i+1];
              w_slot_d[i+1] = r_slot[i];
            end
          end
        end
        w_pass_d = r_pass + PW'(1);
        if (r_pass == PW'(DEPTH - 1)) begin
          w_state_d  = StDrain;
          w_pass_d   = '0;
          w_rd_idx_d = '0;
        end
      end
      StDrain: begin
        if (w_xfer) begin
          if (w_last_rd) begin
            w_state_d  = StLoad;
            w_count_d  = '0;
            w_rd_idx_d = '0;
          end else begin
            w_rd_idx_d = r_rd_idx + CW'(1);
          end
        end
      end
      default: w_state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= StLoad;
      r_count  <= '0;
      r_rd_idx <= '0;
      r_pass   <= '0;
      r_desc   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_count  <= w_count_d;
      r_rd_idx <= w_rd_idx_d;
      r_pass   <= w_pass_d;
      r_desc   <= w_desc_d;
    end
  end

  // Slot contents need no reset; count gates every use of them.
  always_ff @(posedge clk_in) begin
    r_slot <= w_slot_d;
  end
endmodule

// File: tb/tb_n_sort.sv
// Bench for n_sort (DEPTH=4, WIDTH=8): directed cases then random frames
// checked against a queue-sort reference.
module tb_n_sort;
  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  n_sort_if #(.WIDTH(W)) bus ();

  n_sort #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int unsigned frm[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_elems(input bit desc, input bit use_last, input bit toggle);
    int n = frm.size();
    for (int k = 0; k < n; k++) begin
      bus.valid_in   = 1'b1;
      bus.data_in    = frm[k][W-1:0];
      bus.last_in    = use_last && (k == n - 1);
      bus.descend_in = (k == 0) ? desc : (toggle ? ~desc : desc);
      check("ready_out_load", bus.ready_out, 1);
      step();
    end
    bus.valid_in   = 1'b0;
    bus.last_in    = 1'b0;
    bus.descend_in = toggle ? ~desc : desc;
  endtask

  task automatic load_frame(input bit desc, input bit use_last, input bit toggle);
    push_elems(desc, use_last, toggle);
    check("ready_out_after_load", bus.ready_out, 0);
    for (int c = 0; c < D; c++) begin
      check("valid_out_sort", bus.valid_out, 0);
      check("busy_out_sort", bus.busy_out, 1);
      step();
    end
  endtask

  task automatic drain_frame(input bit desc, input int first_stall, input int max_stall);
    int unsigned want[$];
    int n;
    int s;
    want = frm;
    if (desc) want.rsort();
    else want.sort();
    n = want.size();
    for (int k = 0; k < n; k++) begin
      s = (k == 0) ? first_stall : $urandom_range(0, max_stall);
      bus.ready_in = 1'b0;
      for (int j = 0; j < s; j++) begin
        check("valid_out_stall", bus.valid_out, 1);
        check("data_out_stall", bus.data_out, want[k]);
        check("last_out_stall", bus.last_out, (k == n - 1));
        step();
      end
      bus.ready_in = 1'b1;
      check("valid_out", bus.valid_out, 1);
      check("data_out", bus.data_out, want[k]);
      check("last_out", bus.last_out, (k == n - 1));
      step();
    end
    bus.ready_in = 1'b0;
    check("ready_out_after_drain", bus.ready_out, 1);
    check("valid_out_after_drain", bus.valid_out, 0);
    check("busy_out_after_drain", bus.busy_out, 0);
  endtask

  task automatic run_frame(input bit desc, input bit use_last, input bit toggle,
                           input int first_stall, input int max_stall);
    load_frame(desc, use_last, toggle);
    drain_frame(desc, first_stall, max_stall);
  endtask

  initial begin
    int n;
    bit d;
    bit ul;
    rst            = 1'b1;
    bus.data_in    = '0;
    bus.valid_in   = 1'b0;
    bus.last_in    = 1'b0;
    bus.descend_in = 1'b0;
    bus.ready_in   = 1'b0;
    step();
    step();
    check("rst_ready_out", bus.ready_out, 1);
    check("rst_valid_out", bus.valid_out, 0);
    check("rst_last_out", bus.last_out, 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_busy_out", bus.busy_out, 0);
    rst = 1'b0;

    frm = '{3, 1, 2, 0};
    run_frame(1'b0, 1'b1, 1'b0, 0, 0);
    run_frame(1'b1, 1'b1, 1'b1, 0, 0);

    // Stale slots from the previous frame must not leak into a short frame.
    frm = '{200, 5};
    run_frame(1'b0, 1'b1, 1'b0, 0, 0);

    frm = '{7, 255, 7, 0};
    run_frame(1'b0, 1'b0, 1'b0, 0, 0);

    frm = '{3, 1, 2, 0};
    run_frame(1'b0, 1'b1, 1'b0, 3, 0);

    // Reset sampled on the edge of pass 2.
    frm = '{10, 40, 30, 20};
    push_elems(1'b0, 1'b1, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_ready_out", bus.ready_out, 1);
    check("mid_rst_busy_out", bus.busy_out, 0);
    for (int c = 0; c < D + 2; c++) begin
      check("mid_rst_valid_out", bus.valid_out, 0);
      step();
    end
    frm = '{9, 8};
    run_frame(1'b0, 1'b1, 1'b0, 0, 0);

    frm = '{42};
    run_frame(1'b1, 1'b1, 1'b0, 1, 0);

    for (int f = 0; f < 200; f++) begin
      n = $urandom_range(1, D);
      frm.delete();
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 1) == 1) frm.push_back($urandom_range(0, 3));
        else frm.push_back($urandom_range(0, 255));
      end
      d  = 1'($urandom_range(0, 1));
      ul = (n < D) ? 1'b1 : 1'($urandom_range(0, 1));
      run_frame(d, ul, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/n_sort.md
# n_sort

Parametrised sequential sorter, successor to the three-input combinational sort. Accepts a frame of 1..DEPTH unsigned words over a valid/ready input stream. Sorts the frame in place using odd-even transposition, in ascending or descending order selected per frame. Emits the sorted frame over a valid/ready output stream. Sits between sample-capture logic and downstream median/rank processing.

## Interface
- WIDTH, 8, bit width of each unsigned element (>=1)
- DEPTH, 8, maximum elements per frame (>=2); counters are $clog2(DEPTH+1) bits
- clk_in  input  1  single clock, all logic on rising edge
- rst_in  input  1  synchronous, active-high reset
- data_in  input  WIDTH  element to load
- valid_in  input  1  data_in valid
- last_in  input  1  marks final element of frame; qualified by valid_in
- descend_in  input  1  order select, sampled with first element of a frame (1 = largest first)
- ready_out  output  1  block accepts an element this cycle
- data_out  output  WIDTH  sorted element
- valid_out  output  1  data_out valid
- last_out  output  1  marks final sorted element
- ready_in  input  1  downstream accepts data_out
- busy_out  output  1  high in SORT and DRAIN

## Operation
- States: LOAD, SORT, DRAIN.
- LOAD:
  - ready_out=1.
  - Each accepted element (valid_in & ready_out) is written to slot[count]; count increments.
  - descend_in is latched when count==0.
  - Go to SORT when the accepted element has last_in=1, or when count reaches DEPTH. Any further elements are not accepted until the next LOAD.
- SORT:
  - Runs exactly DEPTH pass cycles, regardless of count.
  - Pass p (0-based) compares pairs (i,i+1): even i on even p, odd i on odd p.
  - A pair swaps only if i+1 < count and the pair is out of order for the latched mode.
  - Equal values never swap.
  - Slots >= count are never touched.
  - After pass DEPTH-1, go to DRAIN with rd_idx=0.
- DRAIN:
  - valid_out=1, data_out=slot[rd_idx], last_out=(rd_idx==count-1).
  - On valid_out & ready_in, rd_idx increments.
  - On the transfer with last_out=1, go to LOAD with count=0.
  - While ready_in=0, data_out, valid_out and last_out hold stable.
- Ascending mode emits the smallest element first; descending emits the largest first.
- Arithmetic: unsigned comparison only, WIDTH-bit. There is no wrap or overflow of data, and count saturates at DEPTH.
- Reset values (from the first clock edge with rst_in=1):
  - state=LOAD, count=0, rd_idx=0, pass counter=0, latched mode=0.
  - ready_out=1, valid_out=0, last_out=0, data_out=0, busy_out=0.
  - Slot contents are don't-care.
- Reset mid-operation: a reset in SORT or DRAIN abandons the frame. No further valid_out is asserted for it.
- rst_in has priority over every handshake in the same cycle.
- Single-element frame: SORT still takes DEPTH cycles, then one output beat with last_out=1.

## Timing
- Load throughput: one element per cycle.
- If the final element is accepted on edge t:
  - SORT passes occur on edges t+1..t+DEPTH.
  - valid_out is first high in the cycle after edge t+DEPTH.
- Drain: one element per cycle while ready_in=1.
- ready_out returns to 1 in the cycle after the last_out transfer. There is no overlap between draining one frame and loading the next.
- Full frame with no stall: DEPTH load cycles + DEPTH sort cycles + DEPTH drain cycles.
- ready_out, valid_out, last_out and busy_out are decoded from registered state only. There is no combinational path from any input to any output.

## Test plan
- DEPTH=4, WIDTH=8, descend=0: load 3,1,2,0 (last on 0) -> outputs 0,1,2,3; last_out on 3; first valid_out 4 cycles after final load edge.
- Same data, descend=1 -> 3,2,1,0; mode latched on first element; toggling descend_in mid-frame has no effect.
- Partial frame: load 200,5 with last_in on 5 -> SORT still 4 cycles, outputs 5,200, last_out on 200; untouched slots never emitted.
- Auto-terminate and duplicates: load 7,255,7,0 with no last_in -> ready_out drops after 4th element; outputs 0,7,7,255.
- Backpressure: hold ready_in=0 for 3 cycles after the first valid_out -> data_out stays at the smallest element and valid_out stays 1; the sequence completes unchanged.
- Reset: assert rst_in for 1 cycle during pass 2 -> valid_out never rises for that frame; ready_out=1 next cycle. A new frame 9,8 then sorts to 8,9.
- Regression against the predecessor: exhaustive 3-element frames, all 256^3 (A,B,C) with DEPTH=3 -> output is non-increasing/non-decreasing per mode and a permutation of the inputs.
